counter_load_sequencer: RTL

- Upstream control stage for the loadable up-counter DUT. Drives the counter's data, load and enable inputs and consumes its cout.
- Accepts a command over a valid/ready handshake, loads the preset into the counter, and enables counting until a commanded number of cout pulses is seen. It then pulses done and returns to idle.
- Gives testbenches and system control a single transaction-level interface to the counter.

---
 rtl/counter_seq_pkg.sv | 15 +
 rtl/counter_seq_watchdog.sv | 31 +++
 rtl/counter_load_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and default sizing for the counter load sequencer.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam int unsigned DefaultWidth         = 8;
    localparam int unsigned DefaultRepW          = 8;
    localparam int unsigned DefaultTimeoutCycles = 1024;

endpackage

// File: rtl/counter_seq_watchdog.sv
// RUN-state watchdog: counts cycles since RUN entry or the last cout and flags
// when the count reaches TIMEOUT_CYCLES-1. Only built with COUNTER_SEQ_TIMEOUT_EN.
module counter_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt;

    // Cycle counter; holds at the limit instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (active && (cnt != Limit)) begin
            cnt <= cnt + CntW'(1);
        end
    end

    assign expired = (cnt == Limit);

endmodule

// File: rtl/counter_load_sequencer.sv
// Transaction-level front end for a loadable up-counter: accepts a preset and
// repeat count, loads the counter, enables it until the requested number of
// cout pulses is seen, then pulses done. Optional watchdog under the
// COUNTER_SEQ_TIMEOUT_EN macro adds a timeout output.
module counter_load_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH          = DefaultWidth,
    parameter int unsigned REP_W          = DefaultRepW,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             abort,
    output logic [WIDTH-1:0] data,
    output logic             load,
    output logic             enable,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [REP_W-1:0] cout_seen
`ifdef COUNTER_SEQ_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [REP_W-1:0] reps;
    logic             accept;
    logic             final_cout;
    logic             abort_hit;
    logic             timeout_hit;
    logic             wd_expired;

    // cmd_ready is a registered copy of (state == IDLE), so it gates acceptance.
    assign accept     = cmd_valid && cmd_ready;
    assign final_cout = cout && (cout_seen == (reps - REP_W'(1)));

`ifdef COUNTER_SEQ_TIMEOUT_EN
    logic wd_raw;
    logic run_entry;

    assign run_entry = (state == LOAD) && (state_next == RUN);

    counter_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (run_entry || cout),
        .active (state == RUN),
        .expired(wd_raw)
    );

    // A cout in the expiring cycle counts as progress, so it cancels the timeout.
    assign wd_expired = wd_raw && !cout;
`else
    assign wd_expired = 1'b0;
`endif

    // Next-state decode; abort outranks both completion and timeout.
    always_comb begin
        state_next  = state;
        abort_hit   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                    abort_hit  = 1'b1;
                end else if (reps == '0) begin
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    abort_hit  = 1'b1;
                end else if (final_cout) begin
                    state_next = DONE;
                end else if (wd_expired) begin
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            // done already went out this cycle, so a late abort is not reported.
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, command registers and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            data      <= '0;
            reps      <= '0;
            load      <= 1'b0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cout_seen <= '0;
`ifdef COUNTER_SEQ_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == IDLE);
            load      <= (state_next == LOAD);
            enable    <= (state_next == RUN);
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
            aborted   <= abort_hit;
`ifdef COUNTER_SEQ_TIMEOUT_EN
            timeout   <= timeout_hit;
`endif
            if (accept) begin
                data      <= cmd_data;
                reps      <= cmd_reps;
                cout_seen <= '0;
            end else if ((state == RUN) && cout && (cout_seen != '1)) begin
                cout_seen <= cout_seen + REP_W'(1);
            end
        end
    end

`ifndef COUNTER_SEQ_TIMEOUT_EN
    // Without the watchdog the timeout decode is constant; keep it referenced.
    logic unused_timeout;
    assign unused_timeout = timeout_hit;
`endif

endmodule
